uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Transmit-side sequencer for the APB UART. Accepts bytes from the TX FIFO over a
//  valid/ready handshake and serialises each one onto tx_o as a frame: start, 8 data
//  bits LSB-first, optional parity, 1 or 2 stop bits. Bit timing comes from the
//  clk_div register; framing comes from the cfg register. Sits between the TX FIFO
//  output and the tx_o pin inside uart_top.
// PARAMETERS
//  CLK_DIV_WIDTH  32  width of clk_div_i; bit period in clk_i cycles
//  DATA_BITS      8   data bits per frame (fixed 8 in this release)
// PORTS
//  clk_i          in   1              single clock, all logic rising-edge
//  rst_i          in   1              synchronous reset, active-high
//  tx_en_i        in   1              ctrl_reg TX enable; gates new frame acceptance
//  clk_div_i      in   CLK_DIV_WIDTH  clk_i cycles per bit; 0 is treated as 1
//  parity_en_i    in   1              cfg: insert parity bit
//  parity_odd_i   in   1              cfg: 1 = odd parity, 0 = even parity
//  stop2_i        in   1              cfg: 1 = two stop bits, 0 = one stop bit
//  data_i         in   DATA_BITS      byte from TX FIFO
//  data_valid_i   in   1              data_i valid
//  data_ready_o   out  1              controller accepts data_i this cycle
//  tx_o           out  1              serial line, idle high
//  busy_o         out  1              frame in progress (state != IDLE)
//  frame_done_o   out  1              1-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//  Reset: rst_i sampled at posedge -> state=IDLE, tx_o=1, busy_o=0, frame_done_o=0,
//   bit counter=0, timer=0. data_ready_o=0 whenever rst_i=1 (combinational gate).
//  Reset mid-frame: the frame is dropped. tx_o=1 from the next edge. No pulse.
//  FSM: IDLE -> START -> DATA -> [PARITY if parity_en] -> STOP -> (IDLE | START).
//  Accept: transfer occurs when data_valid_i & data_ready_o at a posedge.
//   data_ready_o = !rst_i & tx_en_i & (state==IDLE | (state==STOP & last stop cycle)).
//  On accept, register data_i, parity_en_i, parity_odd_i, stop2_i, and
//   N = max(clk_div_i,1). Changes to these inputs mid-frame have no effect.
//  Latency: accept at edge k -> tx_o=0 (start) from edge k..k+N, i.e. the registered
//   output changes at the accept edge itself. Each bit is held exactly N cycles.
//  Timer: counts 0..N-1. Bit advances when timer==N-1, then timer resets to 0.
//   Width CLK_DIV_WIDTH; no overflow, since the compare uses the latched N.
//  DATA: bit i = data[i], i=0..7, LSB first. The 3-bit index wraps to 0 on leaving DATA.
//  PARITY: even -> ^data; odd -> ~^data.
//  STOP: tx_o=1 for N cycles (1 stop) or 2N cycles (2 stops).
//  Frame length = N*(10 + parity_en + stop2) cycles.
//  Back-to-back: an accept in the last STOP cycle goes directly to START. There is no
//   idle gap. frame_done_o still pulses in that cycle.
//  tx_en_i deasserted mid-frame: the current frame completes. No further accepts.
//  tx_o, busy_o and frame_done_o are registered. No glitches on tx_o.
// STRUCTURE
//  apb_uart_pkg additions:
//   - typedef enum logic [2:0] uart_tx_state_e {IDLE,START,DATA,PARITY,STOP}
//   - localparam UART_DATA_BITS = 8
//  Sub-module uart_bit_timer: loads N, counts, and emits a bit_tick_o when the count
//   reaches N-1. Clear on rst_i or on load.
//  FSM, shift register and parity generation stay in uart_tx_ctrl.
// TESTING
//  1. clk_div=4, no parity, 1 stop, send 0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1, each bit
//     4 cycles; 40 cycles total; frame_done_o pulses once.
//  2. even parity, 0x07 -> parity bit=1. odd parity, 0x00 -> parity bit=1.
//     Both frames are 44 cycles with clk_div=4.
//  3. stop2=1, clk_div=3, two queued bytes 0xA5, 0x3C -> stop high for 6 cycles; the
//     second start bit immediately follows with no gap; data_ready_o is high in the
//     last stop cycle.
//  4. rst_i asserted at cycle 10 of a frame with clk_div=4 -> tx_o=1 and busy_o=0 on the
//     next cycle; no frame_done_o; the next byte transmits cleanly.
//  5. clk_div=0 with 0xFF -> 1 cycle per bit, 10-cycle frame.
//     Changing clk_div_i mid-frame leaves the frame timing unchanged.
//  6. tx_en_i dropped during DATA with valid held high -> the frame completes;
//     data_ready_o stays 0; tx_o stays idle until tx_en_i returns.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared UART types and constants: transmit FSM states, frame data width and
// the parity helper used by the transmit controller.
package apb_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Even parity makes the total count of ones even; odd parity inverts that.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX FIFO output (master) and the transmit controller (slave).
interface uart_tx_ctrl_if;
  import apb_uart_pkg::*;

  // A byte moves on a rising edge where data_valid_i and data_ready_o are both high;
  // the master holds data_i stable while data_valid_i is high and not yet accepted.
  logic [UART_DATA_BITS-1:0] data_i;
  logic                      data_valid_i;
  logic                      data_ready_o;

  modport master (output data_i, output data_valid_i, input data_ready_o);
  modport slave  (input data_i, input data_valid_i, output data_ready_o);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the period N on load and ticks on the last cycle
// of every bit while enabled.
module uart_bit_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] n_i,
  input  logic         en_i,
  output logic         bit_tick_o,
  output logic         tick_next_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] n_q, n_d;

  assign bit_tick_o = en_i & (cnt_q == n_q - W'(1));

  always_comb begin
    n_d   = load_i ? n_i : n_q;
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_tick_o ? '0 : cnt_q + W'(1);
    end
  end

  // Lets the controller register a pulse that lines up with the final bit cycle.
  assign tick_next_o = (cnt_d == n_d - W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      n_q   <= W'(1);
    end else begin
      cnt_q <= cnt_d;
      n_q   <= n_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts bytes over a valid/ready handshake and
// serialises start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_ctrl
  import apb_uart_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 32,
  parameter int DATA_BITS     = UART_DATA_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tx_en_i,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     stop2_i,
  uart_tx_ctrl_if.slave            fifo,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output uart_tx_state_e           state_o
);

  uart_tx_state_e         state_q, state_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_ph_q, stop_ph_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                     bit_tick, tick_next, last_stop, accept;
  logic [CLK_DIV_WIDTH-1:0] n_load;

  assign n_load    = (clk_div_i == '0) ? CLK_DIV_WIDTH'(1) : clk_div_i;
  assign last_stop = (state_q == STOP) & bit_tick & (stop_ph_q == stop2_q);
  assign fifo.data_ready_o = !rst_i & tx_en_i & ((state_q == IDLE) | last_stop);
  assign accept    = fifo.data_valid_i & fifo.data_ready_o;

  uart_bit_timer #(.W(CLK_DIV_WIDTH)) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept),
    .n_i         (n_load),
    .en_i        (state_q != IDLE),
    .bit_tick_o  (bit_tick),
    .tick_next_o (tick_next)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    stop_ph_d = stop_ph_q;
    tx_d      = tx_q;
    if (accept) begin
      // Framing is captured with the byte so mid-frame config writes are ignored.
      state_d   = START;
      data_d    = fifo.data_i;
      par_en_d  = parity_en_i;
      par_odd_d = parity_odd_i;
      stop2_d   = stop2_i;
      bit_idx_d = '0;
      stop_ph_d = 1'b0;
      tx_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: tx_d = 1'b1;
        START: if (bit_tick) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
        DATA: if (bit_tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_bit(data_q, par_odd_q);
            end else begin
              state_d   = STOP;
              stop_ph_d = 1'b0;
              tx_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_d];
          end
        end
        PARITY: if (bit_tick) begin
          state_d   = STOP;
          stop_ph_d = 1'b0;
          tx_d      = 1'b1;
        end
        STOP: if (bit_tick) begin
          if (stop_ph_q == stop2_q) state_d = IDLE;
          else                      stop_ph_d = 1'b1;
          tx_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    // High during the cycle that will be the last one of the final stop bit.
    done_d = (state_d == STOP) & (stop_ph_d == stop2_d) & tick_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_ph_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      stop_ph_q <= stop_ph_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of frames with hand-computed parity
// and frame length, plus sequences for back-to-back, reset and TX-enable cases.
module tb_uart_tx_ctrl;
  import apb_uart_pkg::*;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic        exp_par;
    int          exp_len;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           tx_en;
  logic [31:0]    clk_div;
  logic           parity_en, parity_odd, stop2;
  logic           tx, busy, frame_done;
  uart_tx_state_e state;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[7];

  uart_tx_ctrl_if u_if ();

  uart_tx_ctrl #(.CLK_DIV_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_en_i      (tx_en),
    .clk_div_i    (clk_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .fifo         (u_if.slave),
    .tx_o         (tx),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    clk_div         = v.div;
    parity_en       = v.par_en;
    parity_odd      = v.par_odd;
    stop2           = v.stop2;
    u_if.data_i       = v.data;
    u_if.data_valid_i = 1'b1;
  endtask

  // Samples every cycle of a frame starting with the first negedge after the accept edge.
  task automatic check_frame(input vec_t v, input int drop_at);
    logic [11:0] bits;
    int nb, n, b;
    logic e;
    n = (v.div == 0) ? 1 : int'(v.div);
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
    bits[9] = v.exp_par;
    nb = v.par_en ? 10 : 9;
    for (int c = 0; c < v.exp_len; c++) begin
      @(negedge clk);
      b = c / n;
      e = (b < nb) ? bits[b] : 1'b1;
      chk($sformatf("tx_c%0d", c), tx, e);
      chk("busy_frame", busy, 1);
      chk("frame_done", frame_done, (c == v.exp_len - 1));
      chk("ready_frame", u_if.data_ready_o, (tx_en && c == v.exp_len - 1));
      if (c == drop_at) tx_en = 1'b0;
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
  endtask

  task automatic run_frame(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    #1 chk("ready_idle", u_if.data_ready_o, 1);
    @(posedge clk);
    #1 u_if.data_valid_i = 1'b0;
    clk_div    = v.div + 32'd5;
    parity_en  = ~v.par_en;
    parity_odd = ~v.par_odd;
    stop2      = ~v.stop2;
    check_frame(v, -1);
    check_idle();
  endtask

  initial begin
    vec_t v, v2;
    int done_cnt;
    tbl[0] = '{8'h55, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 40};
    tbl[1] = '{8'h07, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 44};
    tbl[2] = '{8'h00, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1, 44};
    tbl[3] = '{8'hFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    tbl[4] = '{8'hA5, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    tbl[5] = '{8'h3C, 32'd2, 1'b1, 1'b1, 1'b1, 1'b1, 24};
    tbl[6] = '{8'h80, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 11};

    rst = 1'b1;
    tx_en = 1'b1;
    clk_div = 32'd4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop2 = 1'b0;
    u_if.data_i = 8'h00;
    u_if.data_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", u_if.data_ready_o, 0);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    u_if.data_valid_i = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Two queued bytes with two stop bits: second start must follow with no gap.
    v  = tbl[4];
    v2 = '{8'h3C, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    @(negedge clk);
    drive_vec(v);
    @(posedge clk);
    #1 u_if.data_i = v2.data;
    check_frame(v, -1);
    @(posedge clk);
    #1 u_if.data_valid_i = 1'b0;
    check_frame(v2, -1);
    check_idle();

    // Reset part-way through a frame drops it without a done pulse.
    @(negedge clk);
    drive_vec(tbl[0]);
    @(posedge clk);
    #1 u_if.data_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    u_if.data_valid_i = 1'b1;
    #1 chk("midrst_ready", u_if.data_ready_o, 0);
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    u_if.data_valid_i = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_tx_idle", tx, 1);
    run_frame(tbl[1]);

    // TX enable dropped during DATA: frame finishes, no further accept until re-enabled.
    v = '{8'h96, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 20};
    @(negedge clk);
    drive_vec(v);
    @(posedge clk);
    #1 u_if.data_i = 8'h11;
    check_frame(v, 6);
    repeat (8) begin
      @(negedge clk);
      chk("dis_tx", tx, 1);
      chk("dis_busy", busy, 0);
      chk("dis_ready", u_if.data_ready_o, 0);
    end
    u_if.data_i = v.data;
    tx_en = 1'b1;
    #1 chk("reen_ready", u_if.data_ready_o, 1);
    @(posedge clk);
    #1 u_if.data_valid_i = 1'b0;
    check_frame(v, -1);
    check_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
